// File: rtl/noc_inject_queue.sv
// Source-side injection queue: FWFT FIFO between a PE and its router's local port,
// with optional enqueue-cycle timestamping of the payload and occupancy/injection stats.
module noc_inject_queue #(
    parameter int X                 = 4,
    parameter int Y                 = 4,
    parameter int data_width        = 256,
    parameter int pkt_no_field_size = 0,
    parameter int x_size            = $clog2(X),
    parameter int y_size            = $clog2(Y),
    parameter int total_width       = x_size + y_size + data_width + pkt_no_field_size,
    parameter int DEPTH             = 8,
    parameter int STAMP             = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [total_width-1:0]     i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [total_width-1:0]     o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     o_occupancy,
    output logic [$clog2(DEPTH):0]     o_max_occupancy,
    output logic [31:0]                o_injected_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int HDR_W = x_size + y_size;
    localparam int UP_W  = total_width - HDR_W;

    logic [total_width-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       next_count;
    logic [CNT_W-1:0]       max_occ;
    logic [31:0]            cycle_cnt;
    logic [31:0]            inj_cnt;
    logic [UP_W-1:0]        upper;
    logic                   push;
    logic                   pop;
    logic                   unused_ok;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign o_ready          = (count != CNT_W'(DEPTH));
    assign o_valid          = (count != '0);
    assign o_data           = mem[rd_ptr];
    assign o_occupancy      = count;
    assign o_max_occupancy  = max_occ;
    assign o_injected_count = inj_cnt;

    assign push = i_valid & o_ready;
    assign pop  = o_valid & i_ready;

    // Some bits of i_data / cycle_cnt are legitimately unused depending on STAMP and widths.
    assign unused_ok = ^{i_data, cycle_cnt};

    generate
        if (STAMP != 0) begin : g_stamp
            if (UP_W > 32) begin : g_ext
                assign upper = {{(UP_W-32){1'b0}}, cycle_cnt};
            end else begin : g_trunc
                assign upper = cycle_cnt[UP_W-1:0];
            end
        end else begin : g_pass
            assign upper = i_data[total_width-1:HDR_W];
        end
    endgenerate

    always_comb begin
        next_count = count;
        if (flush)
            next_count = '0;
        else if (push && !pop)
            next_count = count + CNT_W'(1);
        else if (pop && !push)
            next_count = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cycle_cnt <= '0;
            max_occ   <= '0;
            inj_cnt   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            count     <= next_count;
            if (next_count > max_occ)
                max_occ <= next_count;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop) begin
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                    inj_cnt <= sat_inc(inj_cnt);
                end
            end
        end
    end

    // Storage is data-only: no reset, contents behind the pointers are don't-care.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst)
            mem[wr_ptr] <= {upper, i_data[HDR_W-1:0]};
    end

endmodule

// File: tb/tb_noc_inject_queue.sv
// Directed bench for noc_inject_queue (X=Y=4, data_width=8, DEPTH=4, STAMP=1) with a
// queue-based reference model checked every cycle plus hand-computed literal checks.
module tb_noc_inject_queue;

    localparam int TW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [TW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          flush;
    logic [2:0]    o_occupancy;
    logic [2:0]    o_max_occupancy;
    logic [31:0]   o_injected_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    noc_inject_queue #(
        .X(4), .Y(4), .data_width(8), .pkt_no_field_size(0), .DEPTH(4), .STAMP(1)
    ) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .flush(flush),
        .o_occupancy(o_occupancy), .o_max_occupancy(o_max_occupancy),
        .o_injected_count(o_injected_count)
    );

    always #5 clk = ~clk;

    // Reference model: a packet queue, a free-running cycle number and two statistics.
    logic [TW-1:0] mq[$];
    logic [31:0]   m_cyc = 0;
    int            m_max = 0;
    logic [31:0]   m_inj = 0;

    always @(posedge clk) begin
        bit do_push, do_pop;
        if (rst) begin
            mq.delete();
            m_cyc = 0;
            m_max = 0;
            m_inj = 0;
        end else begin
            do_push = i_valid && (mq.size() < 4);
            do_pop  = i_ready && (mq.size() > 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (do_pop) begin
                    void'(mq.pop_front());
                    if (m_inj != 32'hFFFF_FFFF) m_inj = m_inj + 1;
                end
                if (do_push) mq.push_back({m_cyc[7:0], i_data[3:0]});
                if (mq.size() > m_max) m_max = mq.size();
            end
            m_cyc = m_cyc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", 32'(o_valid), 32'(mq.size() != 0));
            check("m_ready", 32'(o_ready), 32'(mq.size() != 4));
            check("m_occ", 32'(o_occupancy), 32'(mq.size()));
            check("m_max", 32'(o_max_occupancy), 32'(m_max));
            check("m_inj", o_injected_count, m_inj);
            if (mq.size() != 0) check("m_data", 32'(o_data), 32'(mq[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [3:0] hdr0);
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b1;
            i_data  = {8'($urandom_range(0, 255)), 4'(hdr0 + k)};
            tick();
        end
        i_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_data = '0; i_valid = 1'b0; i_ready = 1'b0; flush = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_occ", 32'(o_occupancy), 32'd0);
        check("rst_max", 32'(o_max_occupancy), 32'd0);
        check("rst_inj", o_injected_count, 32'd0);

        // Single packet stamped with cycle 5
        repeat (5) tick();
        i_valid = 1'b1; i_data = 12'h0F6; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        check("s1_valid", 32'(o_valid), 32'd1);
        check("s1_data", 32'(o_data), 32'h056);
        tick();
        check("s1_valid_gone", 32'(o_valid), 32'd0);
        check("s1_inj", o_injected_count, 32'd1);
        check("s1_max", 32'(o_max_occupancy), 32'd1);

        // Fill with back-pressure, fifth packet refused
        i_ready = 1'b0;
        push_n(4, 4'h1);
        check("s2_ready", 32'(o_ready), 32'd0);
        check("s2_occ", 32'(o_occupancy), 32'd4);
        check("s2_max", 32'(o_max_occupancy), 32'd4);
        i_valid = 1'b1; i_data = 12'hAB9;
        tick();
        i_valid = 1'b0;
        check("s2_occ_held", 32'(o_occupancy), 32'd4);
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("s2_order", 32'(o_data[3:0]), 32'(k));
            tick();
        end
        check("s2_empty", 32'(o_valid), 32'd0);
        check("s2_inj", o_injected_count, 32'd5);

        // Steady state at count=2 for 20 cycles
        i_ready = 1'b0;
        push_n(2, 4'h0);
        i_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_valid = 1'b1;
            i_data  = {8'($urandom_range(0, 255)), 4'(k + 2)};
            check("s3_order", 32'(o_data[3:0]), 32'(k[3:0]));
            tick();
            check("s3_occ", 32'(o_occupancy), 32'd2);
        end
        i_valid = 1'b0;
        check("s3_inj", o_injected_count, 32'd25);
        repeat (2) tick();

        // Full with simultaneous pop: push refused
        i_ready = 1'b0;
        push_n(4, 4'h8);
        i_valid = 1'b1; i_ready = 1'b1; i_data = 12'h3C5;
        check("s4_ready_full", 32'(o_ready), 32'd0);
        tick();
        i_valid = 1'b0;
        check("s4_occ", 32'(o_occupancy), 32'd3);
        check("s4_ready", 32'(o_ready), 32'd1);
        check("s4_head", 32'(o_data[3:0]), 32'h9);
        repeat (3) tick();
        check("s4_inj", o_injected_count, 32'd31);

        // Reset with 2 packets queued, then push on first post-reset edge
        i_ready = 1'b0;
        push_n(2, 4'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s6_valid", 32'(o_valid), 32'd0);
        check("s6_occ", 32'(o_occupancy), 32'd0);
        check("s6_max", 32'(o_max_occupancy), 32'd0);
        check("s6_inj", o_injected_count, 32'd0);
        i_valid = 1'b1; i_data = 12'hFFD;
        tick();
        i_valid = 1'b0;
        check("s6_stamp0", 32'(o_data), 32'h00D);
        i_ready = 1'b1;
        tick();

        // Flush with 3 queued, concurrent push and pop ignored
        i_ready = 1'b0;
        push_n(3, 4'h4);
        flush = 1'b1; i_valid = 1'b1; i_ready = 1'b1; i_data = 12'h777;
        tick();
        flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        check("s5_valid", 32'(o_valid), 32'd0);
        check("s5_occ", 32'(o_occupancy), 32'd0);
        check("s5_inj", o_injected_count, 32'd1);
        check("s5_max", 32'(o_max_occupancy), 32'd3);
        push_n(1, 4'hE);
        check("s5_after", 32'(o_data[3:0]), 32'hE);
        i_ready = 1'b1;
        repeat (2) tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
